sevenseg_dot_reader: RTL and testbench
======================================

Name: sevenseg_dot_reader

Overview:
- Receive-side counterpart of the seven-segment-with-dot display driver.
- Samples a single-digit segment bus (a–g plus dp) on the shared timer tick and decodes each hex glyph back to a nibble.
- Protocol: dp=1 marks the high nibble, dp=0 the low nibble. The block reassembles the byte and presents it on a valid/ready output.
- Used in loopback self-test and to read a display bus from a neighbouring board.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth for seg_* and en (legal range 2..4).
- SEG_ACTIVE_LOW, 0: 1 = segment inputs are active-low; they are inverted before decode.
- TIMEOUT_TICKS, 8: maximum ticks spent in WAIT_LO before an error is raised (legal range 1..255).

Ports:
- aclk  in  1  clock, 20 MHz, rising edge
- aresetn  in  1  reset, synchronous to aclk, active-low
- tick  in  1  single-cycle strobe, synchronous to aclk, once per N cycles
- en  in  1  asynchronous enable, active-high
- seg_a..seg_g  in  1 each  segment inputs, asynchronous
- seg_dot  in  1  dp segment, asynchronous
- m_data  out  8  reassembled byte {hi, lo}
- m_valid  out  1  byte available
- m_ready  in  1  consumer accepts the byte
- err_glyph  out  1  one-cycle pulse: undecodable pattern sampled
- err_timeout  out  1  one-cycle pulse: low nibble not seen in time
- overflow  out  1  one-cycle pulse: completed byte dropped because m_valid was still held

Behaviour:
- **Reset** (aresetn=0 at an aclk edge): FSM goes to IDLE; m_data=0x00; m_valid, err_glyph, err_timeout and overflow all 0; synchronisers cleared; timeout counter 0. Reset mid-byte discards the partial high nibble.
- **Synchronisers:** seg_* and en pass through SYNC_STAGES flops. Polarity inversion (if SEG_ACTIVE_LOW=1) is applied after synchronisation. The glyph vector is ordered {g,f,e,d,c,b,a}.
- **Sampling:** only on cycles where tick=1 and synchronised en=1. While en_sync=0, the FSM is forced to IDLE, but any m_valid already raised is kept until accepted.
- **Decode** (active-high, {g..a}):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - 00 = blank: ignored in every state, no error, timeout counter still advances.
  - Any other pattern is invalid.
- **FSM states:** IDLE, WAIT_LO.
  - IDLE, valid glyph with dp=1: latch hi nibble, clear the timeout counter, go to WAIT_LO.
  - IDLE, valid glyph with dp=0: ignored (stream is unaligned).
  - WAIT_LO, valid glyph with dp=1: overwrite hi nibble, restart the timeout counter, stay.
  - WAIT_LO, valid glyph with dp=0: the byte completes; go to IDLE.
  - WAIT_LO, any other sampled tick: counter +1. When the counter reaches TIMEOUT_TICKS, pulse err_timeout and go to IDLE.
  - Any state, invalid glyph: pulse err_glyph and go to IDLE.
- **Byte completion:**
  - If m_valid=0, or m_valid=1 and m_ready=1 in the same cycle: m_data={hi,lo} and m_valid=1 on the next cycle. Latency is 1 cycle after the completing tick.
  - If m_valid=1 and m_ready=0: the new byte is dropped, overflow pulses, and m_data is unchanged.
- **Output handshake:**
  - m_valid stays high, with m_data stable, until a cycle with m_ready=1. It falls the following cycle unless a completion coincides with that cycle.
  - m_ready is ignored while m_valid=0.
- **Error pulses** are registered and last exactly one cycle. They are mutually exclusive per tick.

Decomposition:
- Shared package sevenseg_pkg holds:
  - the 16 glyph constants and the blank constant (7-bit);
  - a decode function returning {valid, nibble[3:0]};
  - FSM state encoding.
  The existing driver's encoder uses the same constants.
- One sub-module: sevenseg_sync, a parameterised N-stage synchroniser for an 8-bit vector plus en. It is reusable.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles with ticks active → all outputs 0 and m_data=0x00. Release, then drive glyph 4F with dp=1 followed by 79 with dp=0 → m_data=0x3E and m_valid=1 one cycle after the second tick.
- Backpressure: complete 0xA5 with m_ready=0, then complete 0x12 → overflow pulse of 1 cycle, m_data remains 0xA5. Raise m_ready → m_valid falls on the next cycle.
- Invalid glyph: in WAIT_LO sample 0x55 → err_glyph pulses 1 cycle, FSM returns to IDLE, no m_valid. The next dp=0 glyph is ignored.
- Timeout (TIMEOUT_TICKS=8): send hi glyph 7F with dp=1, then 8 blank ticks → err_timeout on the 8th, FSM returns to IDLE, m_valid stays 0.
- Re-alignment and blanks: send 06/dp=1, then 6D/dp=1, then blank, then 3F/dp=0 → m_data=0x50 (hi nibble overwritten, blank ignored).
- Enable and reset: deassert en mid-byte → the partial byte is discarded and reassembly restarts from a dp=1 glyph. Assert aresetn=0 while m_valid=1 → m_valid=0 on the next edge.

Source files
------------

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_pkg
// Brief  : Shared definitions for the seven-segment-with-dot link. Holds the
//          hex glyph constants (active-high, ordered {g,f,e,d,c,b,a}), the
//          blank glyph, a glyph-to-nibble decode function and the reader FSM
//          state encoding. The display driver's encoder uses the same
//          glyph constants, so both ends agree on the character set.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Reader FSM: IDLE waits for a dp=1 (high nibble) glyph, WAIT_LO waits
  // for the dp=0 (low nibble) glyph that completes the byte.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_LO = 1'b1
  } state_t;

  // Returns {valid, nibble}. Blank and every non-hex pattern return valid=0;
  // callers that treat blank specially must test for it before decoding.
  function automatic logic [4:0] decode_glyph(input logic [6:0] glyph);
    logic [4:0] result;
    result = 5'b0_0000;
    case (glyph)
      GLYPH_0: result = {1'b1, 4'h0};
      GLYPH_1: result = {1'b1, 4'h1};
      GLYPH_2: result = {1'b1, 4'h2};
      GLYPH_3: result = {1'b1, 4'h3};
      GLYPH_4: result = {1'b1, 4'h4};
      GLYPH_5: result = {1'b1, 4'h5};
      GLYPH_6: result = {1'b1, 4'h6};
      GLYPH_7: result = {1'b1, 4'h7};
      GLYPH_8: result = {1'b1, 4'h8};
      GLYPH_9: result = {1'b1, 4'h9};
      GLYPH_A: result = {1'b1, 4'hA};
      GLYPH_B: result = {1'b1, 4'hB};
      GLYPH_C: result = {1'b1, 4'hC};
      GLYPH_D: result = {1'b1, 4'hD};
      GLYPH_E: result = {1'b1, 4'hE};
      GLYPH_F: result = {1'b1, 4'hF};
      default: result = 5'b0_0000;
    endcase
    return result;
  endfunction

endpackage : sevenseg_pkg
`default_nettype wire

// File: rtl/sevenseg_sync.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_sync
// Brief  : N-stage flip-flop synchroniser for an 8-bit vector plus an enable
//          bit. All stages clear on synchronous active-low reset.
// Ports  : clk       in   clock
//          rst_n     in   synchronous reset, active-low
//          data_in   in   8-bit asynchronous vector
//          en_in     in   asynchronous enable
//          data_out  out  synchronised vector
//          en_out    out  synchronised enable
// Rev    : 1.0 - initial release
// ============================================================================
module sevenseg_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       en_in,
  output logic [7:0] data_out,
  output logic       en_out
);

  // Enable travels in bit 8 alongside the data so both see identical latency.
  logic [8:0] stage_q [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!rst_n) stage_q[i] <= '0;
        else        stage_q[i] <= {en_in, data_in};
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (!rst_n) stage_q[i] <= '0;
        else        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_out = stage_q[STAGES-1][7:0];
  assign en_out   = stage_q[STAGES-1][8];

endmodule : sevenseg_sync
`default_nettype wire

// File: rtl/sevenseg_dot_reader.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_dot_reader
// Brief  : Receive side of the seven-segment-with-dot link. Samples the
//          synchronised segment bus on each enabled tick, decodes hex glyphs
//          and reassembles {hi, lo} bytes (dp=1 marks hi, dp=0 marks lo),
//          presenting them on a valid/ready output.
// Ports  : aclk         in   clock
//          aresetn      in   synchronous reset, active-low
//          tick         in   single-cycle sample strobe (aclk domain)
//          en           in   asynchronous enable
//          seg_a..seg_g in   asynchronous segment inputs
//          seg_dot      in   asynchronous dp segment
//          m_data       out  reassembled byte
//          m_valid      out  byte available
//          m_ready      in   consumer accepts byte
//          err_glyph    out  1-cycle pulse, undecodable pattern sampled
//          err_timeout  out  1-cycle pulse, low nibble not seen in time
//          overflow     out  1-cycle pulse, completed byte dropped
// Rev    : 1.0 - initial release
// ============================================================================
module sevenseg_dot_reader
  import sevenseg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int TIMEOUT_TICKS  = 8
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       tick,
  input  logic       en,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  input  logic       seg_dot,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       err_glyph,
  output logic       err_timeout,
  output logic       overflow
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_TICKS);

  logic [7:0] seg_raw;
  logic [7:0] seg_sync;
  logic       en_sync;
  logic [6:0] glyph;
  logic       dot;
  logic [4:0] decoded;
  logic       sample;

  state_t     state, state_next;
  logic [3:0] hi_nib, hi_nib_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic [7:0] data_next;
  logic       valid_next;
  logic       err_glyph_next;
  logic       err_timeout_next;
  logic       overflow_next;
  logic       complete;

  assign seg_raw = {seg_dot, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};

  sevenseg_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (aclk),
    .rst_n    (aresetn),
    .data_in  (seg_raw),
    .en_in    (en),
    .data_out (seg_sync),
    .en_out   (en_sync)
  );

  // Inversion happens after the synchroniser so the flops always see the
  // raw pin levels; the dp pin shares the bus polarity.
  assign glyph   = seg_sync[6:0] ^ {7{SEG_ACTIVE_LOW}};
  assign dot     = seg_sync[7] ^ SEG_ACTIVE_LOW;
  assign decoded = decode_glyph(glyph);
  assign sample  = tick & en_sync;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      hi_nib      <= 4'h0;
      wait_cnt    <= 8'd0;
      m_data      <= 8'h00;
      m_valid     <= 1'b0;
      err_glyph   <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      hi_nib      <= hi_nib_next;
      wait_cnt    <= wait_cnt_next;
      m_data      <= data_next;
      m_valid     <= valid_next;
      err_glyph   <= err_glyph_next;
      err_timeout <= err_timeout_next;
      overflow    <= overflow_next;
    end
  end

  always_comb begin
    state_next       = state;
    hi_nib_next      = hi_nib;
    wait_cnt_next    = wait_cnt;
    err_glyph_next   = 1'b0;
    err_timeout_next = 1'b0;
    complete         = 1'b0;

    if (!en_sync) begin
      // Disabled: drop any partial byte, but the output side is untouched.
      state_next    = ST_IDLE;
      wait_cnt_next = 8'd0;
    end else if (sample) begin
      if (glyph == GLYPH_BLANK) begin
        // Blanks are never errors but still consume timeout budget.
        if (state == ST_WAIT_LO) begin
          wait_cnt_next = wait_cnt + 8'd1;
          if (wait_cnt_next == TIMEOUT_LIMIT) begin
            err_timeout_next = 1'b1;
            state_next       = ST_IDLE;
            wait_cnt_next    = 8'd0;
          end
        end
      end else if (!decoded[4]) begin
        err_glyph_next = 1'b1;
        state_next     = ST_IDLE;
        wait_cnt_next  = 8'd0;
      end else if (dot) begin
        // A hi glyph always (re)starts a byte, from either state.
        hi_nib_next   = decoded[3:0];
        wait_cnt_next = 8'd0;
        state_next    = ST_WAIT_LO;
      end else if (state == ST_WAIT_LO) begin
        complete      = 1'b1;
        state_next    = ST_IDLE;
        wait_cnt_next = 8'd0;
      end
    end
  end

  // Output holding register: a completion may land in the same cycle the
  // consumer accepts, which reloads instead of letting m_valid fall.
  always_comb begin
    data_next     = m_data;
    valid_next    = m_valid;
    overflow_next = 1'b0;
    if (complete) begin
      if (!m_valid || m_ready) begin
        data_next  = {hi_nib, decoded[3:0]};
        valid_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end else if (m_valid && m_ready) begin
      valid_next = 1'b0;
    end
  end

endmodule : sevenseg_dot_reader
`default_nettype wire

// File: tb/tb_sevenseg_dot_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_sevenseg_dot_reader
// Brief  : Self-checking bench for sevenseg_dot_reader: directed scenarios
//          followed by randomized glyph streams checked against a
//          transaction-level reference model.
// Ports  : none
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_dot_reader;

  localparam int SYNC   = 2;
  localparam int TMO    = 8;
  localparam int SETTLE = SYNC + 1;

  logic       aclk = 1'b0;
  logic       aresetn, tick, en, m_ready;
  logic [6:0] glyph_drv;
  logic       dp_drv;
  logic [7:0] m_data;
  logic       m_valid, err_glyph, err_timeout, overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #25 aclk = ~aclk;

  sevenseg_dot_reader #(
    .SYNC_STAGES   (SYNC),
    .SEG_ACTIVE_LOW(1'b0),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .tick       (tick),
    .en         (en),
    .seg_a      (glyph_drv[0]),
    .seg_b      (glyph_drv[1]),
    .seg_c      (glyph_drv[2]),
    .seg_d      (glyph_drv[3]),
    .seg_e      (glyph_drv[4]),
    .seg_f      (glyph_drv[5]),
    .seg_g      (glyph_drv[6]),
    .seg_dot    (dp_drv),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .err_glyph  (err_glyph),
    .err_timeout(err_timeout),
    .overflow   (overflow)
  );

  // ---------------- reference model (transaction level) ----------------
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] bad_tab [6]  = '{7'h55, 7'h01, 7'h7E, 7'h40, 7'h2A, 7'h08};

  bit       mdl_have_hi;
  int       mdl_hi;
  int       mdl_blanks;
  bit       mdl_valid;
  bit [7:0] mdl_data;
  bit       mdl_eg, mdl_et, mdl_ov;

  function automatic int lookup(input logic [6:0] g);
    for (int k = 0; k < 16; k++) if (hex_tab[k] == g) return k;
    return -1;
  endfunction

  // Applies one clock edge's worth of spec rules using the inputs held
  // before that edge.
  task automatic model_edge();
    int  idx;
    bit  done;
    bit [7:0] word;
    done = 0; word = 0;
    mdl_eg = 0; mdl_et = 0; mdl_ov = 0;
    if (!aresetn) begin
      mdl_have_hi = 0; mdl_blanks = 0; mdl_valid = 0; mdl_data = 0;
      return;
    end
    if (!en) begin
      mdl_have_hi = 0;
    end else if (tick) begin
      idx = lookup(glyph_drv);
      if (glyph_drv == 7'h00) begin
        if (mdl_have_hi) begin
          mdl_blanks++;
          if (mdl_blanks >= TMO) begin mdl_et = 1; mdl_have_hi = 0; end
        end
      end else if (idx < 0) begin
        mdl_eg = 1; mdl_have_hi = 0;
      end else if (dp_drv) begin
        mdl_hi = idx; mdl_have_hi = 1; mdl_blanks = 0;
      end else if (mdl_have_hi) begin
        done = 1; word = 8'(mdl_hi * 16 + idx); mdl_have_hi = 0;
      end
    end
    if (done) begin
      if (!mdl_valid || m_ready) begin mdl_data = word; mdl_valid = 1; end
      else mdl_ov = 1;
    end else if (mdl_valid && m_ready) begin
      mdl_valid = 0;
    end
  endtask

  // Advance one clock; inputs may be changed after this returns.
  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  // Present a glyph long enough to cross the synchroniser, then tick once.
  task automatic send(input logic [6:0] g, input logic d);
    glyph_drv = g; dp_drv = d; tick = 1'b0;
    repeat (SETTLE) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic flush();
    m_ready = 1'b1;
    repeat (2) step();
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0; en = 1'b1; m_ready = 1'b0; glyph_drv = 7'h3F; dp_drv = 1'b1;
    repeat (3) begin tick = 1'b1; step(); end
    tick = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h want=00", m_data); end
    n_cmp++; if ({err_glyph, err_timeout, overflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got=%b want=000", {err_glyph, err_timeout, overflow}); end
    aresetn = 1'b1;
    send(7'h4F, 1'b1);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL first_hi_valid got=%b want=0", m_valid); end
    send(7'h79, 1'b0);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h3E) begin
      n_fail++; $display("FAIL first_byte got=%b/%h want=1/3e", m_valid, m_data); end
  endtask

  task automatic test_backpressure();
    flush();
    m_ready = 1'b0;
    send(7'h77, 1'b1);
    send(7'h6D, 1'b0);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL bp_first got=%b/%h want=1/a5", m_valid, m_data); end
    send(7'h06, 1'b1);
    send(7'h5B, 1'b0);
    n_cmp++; if (overflow !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL bp_overflow got=%b/%h want=1/a5", overflow, m_data); end
    step();
    n_cmp++; if (overflow !== 1'b0 || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_ovf_width got=%b/%b want=0/1", overflow, m_valid); end
    m_ready = 1'b1;
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b want=0", m_valid); end
  endtask

  task automatic test_invalid();
    flush();
    send(7'h7F, 1'b1);
    send(7'h55, 1'b0);
    n_cmp++; if (err_glyph !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL inv_pulse got=%b/%b want=1/0", err_glyph, m_valid); end
    step();
    n_cmp++; if (err_glyph !== 1'b0) begin n_fail++; $display("FAIL inv_width got=%b want=0", err_glyph); end
    send(7'h3F, 1'b0);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL inv_realign got=%b want=0", m_valid); end
  endtask

  task automatic test_timeout();
    flush();
    send(7'h7F, 1'b1);
    repeat (TMO - 1) send(7'h00, 1'b0);
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%b want=0", err_timeout); end
    send(7'h00, 1'b0);
    n_cmp++; if (err_timeout !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse got=%b/%b want=1/0", err_timeout, m_valid); end
    step();
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_width got=%b want=0", err_timeout); end
    send(7'h3F, 1'b0);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_idle got=%b want=0", m_valid); end
  endtask

  task automatic test_realign();
    flush();
    send(7'h06, 1'b1);
    send(7'h6D, 1'b1);
    send(7'h00, 1'b0);
    send(7'h3F, 1'b0);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h50) begin
      n_fail++; $display("FAIL realign got=%b/%h want=1/50", m_valid, m_data); end
  endtask

  task automatic test_enable_reset();
    flush();
    send(7'h66, 1'b1);
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    send(7'h3F, 1'b0);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL en_discard got=%b want=0", m_valid); end
    m_ready = 1'b0;
    send(7'h6F, 1'b1);
    send(7'h07, 1'b0);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h97) begin
      n_fail++; $display("FAIL en_restart got=%b/%h want=1/97", m_valid, m_data); end
    aresetn = 1'b0;
    step();
    n_cmp++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_midvalid got=%b/%h want=0/00", m_valid, m_data); end
    aresetn = 1'b1;
  endtask

  // ---------------- randomized stream vs model ----------------
  task automatic test_random();
    int r;
    logic [6:0] g;
    logic d;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 3)      g = 7'h00;
      else if (r < 5) g = bad_tab[$urandom_range(0, 5)];
      else            g = hex_tab[$urandom_range(0, 15)];
      d       = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 2) != 0);
      en      = ($urandom_range(0, 24) != 0);
      send(g, d);
      n_cmp++; if (m_valid !== mdl_valid) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, m_valid, mdl_valid); end
      n_cmp++; if (mdl_valid && m_data !== mdl_data) begin
        n_fail++; $display("FAIL rnd_data[%0d] got=%h want=%h", n, m_data, mdl_data); end
      n_cmp++; if (err_glyph !== mdl_eg) begin
        n_fail++; $display("FAIL rnd_err_glyph[%0d] got=%b want=%b", n, err_glyph, mdl_eg); end
      n_cmp++; if (err_timeout !== mdl_et) begin
        n_fail++; $display("FAIL rnd_err_timeout[%0d] got=%b want=%b", n, err_timeout, mdl_et); end
      n_cmp++; if (overflow !== mdl_ov) begin
        n_fail++; $display("FAIL rnd_overflow[%0d] got=%b want=%b", n, overflow, mdl_ov); end
    end
    en = 1'b1;
  endtask

  initial begin
    tick = 1'b0; en = 1'b0; m_ready = 1'b0; aresetn = 1'b0;
    glyph_drv = 7'h00; dp_drv = 1'b0;
    mdl_have_hi = 0; mdl_hi = 0; mdl_blanks = 0;
    mdl_valid = 0; mdl_data = 0; mdl_eg = 0; mdl_et = 0; mdl_ov = 0;
    #1;
    test_reset();
    test_backpressure();
    test_invalid();
    test_timeout();
    test_realign();
    test_enable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule : tb_sevenseg_dot_reader
`default_nettype wire
